dm_refill_ctrl: RTL and testbench

Miss-refill controller sitting directly downstream of the direct-mapped cache. When the cache reports a miss, this block fetches the full cache line from backing memory one word at a time over a req/ack handshake. It writes each word into the cache data array, then commits the tag and valid bit. It also enforces a per-word memory timeout and keeps a saturating refill counter.

---
 rtl/dm_refill_ctrl.sv | 132 +++++++++++++
 tb/tb_dm_refill_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_refill_ctrl.sv
// Miss-refill controller for a direct-mapped cache: fetches a full line word by word over a
// req/ack memory handshake, writes it into the data array, then commits the tag.
module dm_refill_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned WORDS   = 4,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    miss_valid,
  input  logic [ADDR_W-1:0]                       miss_addr,
  output logic                                    miss_ready,
  output logic                                    mem_req,
  output logic [ADDR_W-1:0]                       mem_addr,
  input  logic                                    mem_ack,
  input  logic [DATA_W-1:0]                       mem_rdata,
  output logic                                    fill_we,
  output logic [INDEX_W-1:0]                      fill_index,
  output logic [$clog2(WORDS)-1:0]                fill_offset,
  output logic [DATA_W-1:0]                       fill_data,
  output logic [ADDR_W-INDEX_W-$clog2(WORDS)-3:0] fill_tag,
  output logic                                    fill_tag_we,
  output logic                                    fill_err,
  output logic [15:0]                             refill_count
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned TAG_W = ADDR_W - INDEX_W - OFF_W - 2;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [OFF_W-1:0]  WLast = OFF_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]  TLast = CNT_W'(TIMEOUT - 1);
  // Clears the offset and byte fields to form the line base address.
  localparam logic [ADDR_W-1:0] LineMask = ~((ADDR_W'(1) << (OFF_W + 2)) - ADDR_W'(1));

  typedef enum logic [2:0] {StIdle, StReq, StWr, StDone, StErr} state_e;

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   w_q, w_d;
  logic [CNT_W-1:0]   t_q, t_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [INDEX_W-1:0] index_q, index_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [15:0]        count_q, count_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      w_q     <= '0;
      t_q     <= '0;
      base_q  <= '0;
      index_q <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      t_q     <= t_d;
      base_q  <= base_d;
      index_q <= index_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    t_d     = t_q;
    base_d  = base_q;
    index_d = index_q;
    tag_d   = tag_q;
    data_d  = data_q;
    count_d = count_q;
    unique case (state_q)
      StIdle: begin
        if (miss_valid) begin
          state_d = StReq;
          w_d     = '0;
          t_d     = '0;
          base_d  = miss_addr & LineMask;
          index_d = miss_addr[OFF_W+2 +: INDEX_W];
          tag_d   = miss_addr[ADDR_W-1 -: TAG_W];
        end
      end
      StReq: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = StWr;
        end else if (t_q == TLast) begin
          state_d = StErr;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StWr: begin
        if (w_q == WLast) begin
          state_d = StDone;
        end else begin
          w_d     = w_q + 1'b1;
          t_d     = '0;
          state_d = StReq;
        end
      end
      StDone: begin
        if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        state_d = StIdle;
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign miss_ready   = (state_q == StIdle);
  assign mem_req      = (state_q == StReq);
  assign mem_addr     = base_q + ADDR_W'({w_q, 2'b00});
  assign fill_we      = (state_q == StWr);
  assign fill_index   = index_q;
  assign fill_offset  = w_q;
  assign fill_data    = data_q;
  assign fill_tag     = tag_q;
  assign fill_tag_we  = (state_q == StDone);
  assign fill_err     = (state_q == StErr);
  assign refill_count = count_q;

endmodule

// File: tb/tb_dm_refill_ctrl.sv
// Randomized bench for dm_refill_ctrl: a latency-programmable memory responder plus a
// line-level reference model of the expected fill sequence, timing and refill counter.
module tb_dm_refill_ctrl;

  localparam int unsigned WORDS   = 4;
  localparam int unsigned INDEX_W = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned OFF_B   = $clog2(WORDS) + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ready;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        fill_we;
  logic [3:0]  fill_index;
  logic [1:0]  fill_offset;
  logic [31:0] fill_data;
  logic [23:0] fill_tag;
  logic        fill_tag_we;
  logic        fill_err;
  logic [15:0] refill_count;

  dm_refill_ctrl #(
    .ADDR_W (32),
    .DATA_W (32),
    .WORDS  (WORDS),
    .INDEX_W(INDEX_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .miss_valid  (miss_valid),
    .miss_addr   (miss_addr),
    .miss_ready  (miss_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .fill_we     (fill_we),
    .fill_index  (fill_index),
    .fill_offset (fill_offset),
    .fill_data   (fill_data),
    .fill_tag    (fill_tag),
    .fill_tag_we (fill_tag_we),
    .fill_err    (fill_err),
    .refill_count(refill_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          exp_count = 0;
  logic [31:0] salt = 32'h1357_9BDF;

  // Responder knobs shared with the main sequence.
  logic [31:0] exp_base = '0;
  int          rw = 0;
  int          cur_lat = 1;
  bit          no_ack = 1'b0;
  bit          stray_ack = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // Memory: acks in the cur_lat-th REQ cycle of each word, checks the requested address.
  initial begin
    int req_cnt;
    req_cnt   = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (stray_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        stray_ack = 1'b0;
      end else if (mem_req) begin
        check_val("mem_addr", 64'(mem_addr), 64'(exp_base + 32'(rw * 4)));
        req_cnt++;
        if (!no_ack && req_cnt == cur_lat) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          rw++;
          req_cnt = 0;
        end
      end else begin
        req_cnt = 0;
      end
    end
  end

  task automatic refill(input logic [31:0] addr, input int lat, input bit noack, input bit hold);
    logic [31:0] base;
    int c, k, reqs, errs, tws, exp_lat;
    base = addr & ~((32'd1 << OFF_B) - 32'd1);
    c = 0;
    while (!miss_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    exp_base   = base;
    rw         = 0;
    cur_lat    = lat;
    no_ack     = noack;
    salt       = $urandom;
    miss_valid = 1'b1;
    miss_addr  = addr;
    @(posedge clk);
    #1;
    if (!hold) miss_valid = 1'b0;
    c = 0; k = 0; reqs = 0; errs = 0; tws = 0;
    while (c < 200) begin
      @(negedge clk);
      c++;
      if (mem_req) reqs++;
      if (fill_we) begin
        check_val("fill_index", 64'(fill_index), 64'(addr[OFF_B +: INDEX_W]));
        check_val("fill_offset", 64'(fill_offset), 64'(k));
        check_val("fill_data", 64'(fill_data), 64'(mem_word(base + 32'(k * 4))));
        k++;
      end
      if (fill_tag_we) begin
        tws++;
        check_val("tag_index", 64'(fill_index), 64'(addr[OFF_B +: INDEX_W]));
        check_val("fill_tag", 64'(fill_tag), 64'(addr >> (OFF_B + INDEX_W)));
        check_val("words_before_tag", 64'(k), 64'(WORDS));
      end
      if (fill_err) errs++;
      if (miss_ready) break;
    end
    miss_valid = 1'b0;
    no_ack     = 1'b0;
    if (!noack && exp_count < 16'hFFFF) exp_count++;
    exp_lat = noack ? TIMEOUT + 2 : WORDS * (lat + 1) + 2;
    check_val("latency", 64'(c), 64'(exp_lat));
    check_val("tag_we_count", 64'(tws), noack ? 64'd0 : 64'd1);
    check_val("err_count", 64'(errs), noack ? 64'd1 : 64'd0);
    if (noack) begin
      check_val("timeout_req_cycles", 64'(reqs), 64'(TIMEOUT));
      check_val("timeout_no_fill", 64'(k), 64'd0);
    end
    check_val("refill_count", 64'(refill_count), 64'(exp_count));
  endtask

  task automatic check_reset_state(input string pfx);
    check_val({pfx, "_miss_ready"}, 64'(miss_ready), 64'd1);
    check_val({pfx, "_mem_req"}, 64'(mem_req), 64'd0);
    check_val({pfx, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check_val({pfx, "_fill_we"}, 64'(fill_we), 64'd0);
    check_val({pfx, "_fill_offset"}, 64'(fill_offset), 64'd0);
    check_val({pfx, "_fill_index"}, 64'(fill_index), 64'd0);
    check_val({pfx, "_fill_data"}, 64'(fill_data), 64'd0);
    check_val({pfx, "_fill_tag"}, 64'(fill_tag), 64'd0);
    check_val({pfx, "_fill_tag_we"}, 64'(fill_tag_we), 64'd0);
    check_val({pfx, "_fill_err"}, 64'(fill_err), 64'd0);
    check_val({pfx, "_refill_count"}, 64'(refill_count), 64'd0);
  endtask

  initial begin
    int c, side;
    rst        = 1'b1;
    miss_valid = 1'b0;
    miss_addr  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state("rst");

    refill(32'h0000_0014, 1, 1'b0, 1'b0);
    refill(32'h1234_5678, 3, 1'b0, 1'b0);
    refill(32'h0000_0214, 1, 1'b0, 1'b0);
    refill(32'hFFFF_FFF8, 2, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      refill($urandom, int'($urandom_range(1, 5)), ($urandom_range(0, 5) == 0), 1'b0);
    end
    refill(32'hCAFE_0040, 1, 1'b1, 1'b0);
    refill(32'h0000_0330, 2, 1'b0, 1'b1);

    // Saturation: preload just below the limit, then two completed refills.
    @(negedge clk);
    force dut.count_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.count_q;
    exp_count = 16'hFFFE;
    refill(32'h0000_1000, 1, 1'b0, 1'b0);
    refill(32'h0000_2010, 1, 1'b0, 1'b0);
    refill(32'h0000_3020, 1, 1'b1, 1'b0);

    // Reset during the WR cycle of word 2.
    exp_base   = 32'h0000_5A50;
    rw         = 0;
    cur_lat    = 1;
    miss_valid = 1'b1;
    miss_addr  = 32'h0000_5A54;
    @(posedge clk);
    #1 miss_valid = 1'b0;
    c = 0;
    while (!(fill_we && fill_offset == 2'd2) && c < 50) begin
      @(negedge clk);
      c++;
    end
    check_val("reached_word2", 64'(c < 50), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    exp_count = 0;
    check_reset_state("midrst");
    stray_ack = 1'b1;
    side = 0;
    repeat (4) begin
      @(negedge clk);
      if (fill_we || fill_tag_we || fill_err || mem_req) side++;
    end
    check_val("post_reset_quiet", 64'(side), 64'd0);
    refill(32'h0000_0084, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
